// File: rtl/ddr5_pwrgd_pkg.sv
// Shared types and constants for the multi-channel DDR5 PWRGD_FAIL controller.
// Holds channel FSM states, fault cause codes and a channel-index width helper.
package ddr5_pwrgd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PSU   = 3'd1,
    ST_DDRIO = 3'd2,
    ST_LINK  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_DDRIO   = 2'b01,
    CAUSE_PGFAIL  = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_t;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr5_pwrgd_ch.sv
// One PWRGD_FAIL channel: pin synchroniser, debounce filter, power-good FSM,
// link timeout and cause register.
// Ports: iClk/iRst; psOk, ddrio, pin in; oe, dramOk, pfOut, memFlt,
// cause, faultEntry out.
module ddr5_pwrgd_ch
  import ddr5_pwrgd_pkg::*;
#(
  parameter int FILT_CYCLES    = 4,
  parameter int LINK_TO_CYCLES = 2000,
  parameter int FAULT_STICKY   = 1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       psOk,
  input  logic       ddrio,
  input  logic       pin,
  output logic       oe,
  output logic       dramOk,
  output logic       pfOut,
  output logic       memFlt,
  output logic [1:0] cause,
  output logic       faultEntry
);

  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int TW =
    (LINK_TO_CYCLES > 0) ? $clog2(LINK_TO_CYCLES + 1) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((LINK_TO_CYCLES > 0) ? LINK_TO_CYCLES - 1 : 0);

  logic          s1, s2, pf;
  logic [FW-1:0] fCnt;
  logic [TW-1:0] toCnt;
  logic          toHit;
  state_t        st, stNext;
  cause_t        causeR, causeNext;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1   <= LOW;
      s2   <= LOW;
      pf   <= LOW;
      fCnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == pf) begin
        fCnt <= '0;
      end else if (fCnt == FILT_LAST) begin
        pf   <= s2;
        fCnt <= '0;
      end else begin
        fCnt <= fCnt + 1'b1;
      end
    end
  end

  // Counter restarts whenever the channel is outside ST_DDRIO, so every
  // entry begins a fresh link-up window.
  assign toHit = (LINK_TO_CYCLES > 0) && (toCnt == TO_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      toCnt <= '0;
    end else if (st == ST_DDRIO) begin
      toCnt <= toCnt + 1'b1;
    end else begin
      toCnt <= '0;
    end
  end

  always_comb begin
    stNext    = st;
    causeNext = causeR;
    unique case (st)
      ST_IDLE: begin
        if (psOk) stNext = ST_PSU;
      end
      ST_PSU: begin
        if (!psOk)      stNext = ST_IDLE;
        else if (ddrio) stNext = ST_DDRIO;
      end
      ST_DDRIO: begin
        if (!psOk) begin
          stNext = ST_IDLE;
        end else if (ddrio && pf) begin
          stNext = ST_LINK;
        end else if (!ddrio) begin
          stNext = ST_PSU;
        end else if (toHit) begin
          stNext    = ST_FAULT;
          causeNext = CAUSE_TIMEOUT;
        end
      end
      ST_LINK: begin
        if (!psOk) begin
          stNext = ST_IDLE;
        end else if (!ddrio) begin
          stNext    = ST_FAULT;
          causeNext = CAUSE_DDRIO;
        end else if (!pf) begin
          stNext    = ST_FAULT;
          causeNext = CAUSE_PGFAIL;
        end
      end
      ST_FAULT: begin
        if (FAULT_STICKY == 0 && !psOk) begin
          stNext    = ST_IDLE;
          causeNext = CAUSE_NONE;
        end
      end
      default: begin
        stNext    = ST_IDLE;
        causeNext = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      st     <= ST_IDLE;
      causeR <= CAUSE_NONE;
      dramOk <= LOW;
    end else begin
      st     <= stNext;
      causeR <= causeNext;
      // Held only while staying in LINK, so it drops on the same edge
      // the channel leaves.
      dramOk <= (st == ST_LINK) && (stNext == ST_LINK);
    end
  end

  assign oe         = (st != ST_DDRIO) && (st != ST_LINK);
  assign memFlt     = (st == ST_FAULT);
  assign cause      = causeR;
  assign pfOut      = pf;
  assign faultEntry = (st != ST_FAULT) && (stNext == ST_FAULT);

endmodule

// File: rtl/ddr5_pwrgd_multi_ch.sv
// Multi-channel DDR5 PWRGD_FAIL controller: per-channel FSMs, ADR pin gate,
// interposer bypass and first-fault capture.
// Ports: iClk/iRst, PSU/DDRIO/MC/ADR/pin inputs; per-channel OE, DRAM OK,
// DIMM reset, fault flag, cause, plus first-fault valid/index.
module ddr5_pwrgd_multi_ch
  import ddr5_pwrgd_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int FILT_CYCLES    = 4,
  parameter int LINK_TO_CYCLES = 2000,
  parameter int FAULT_STICKY   = 1
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iFM_INTR_PRSNT,
  input  logic                          iINTR_SKU,
  input  logic                          iPWRGD_PS_PWROK,
  input  logic [NUM_CH-1:0]             iPWRGD_DRAMPWRGD_DDRIO,
  input  logic [NUM_CH-1:0]             iMC_RST_N,
  input  logic                          iADR_LOGIC,
  input  logic [NUM_CH-1:0]             iPWRGD_FAIL_CH,
  output logic [NUM_CH-1:0]             oPWRGD_FAIL_OE,
  output logic [NUM_CH-1:0]             oPWRGD_DRAMPWRGD_OK,
  output logic [NUM_CH-1:0]             oFPGA_DIMM_RST_N,
  output logic [NUM_CH-1:0]             oDIMM_MEM_FLT,
  output logic [2*NUM_CH-1:0]           oFLT_CAUSE,
  output logic                          oFIRST_FLT_VALID,
  output logic [chWidth(NUM_CH)-1:0]    oFIRST_FLT_CH
);

  localparam int CHW = chWidth(NUM_CH);

  logic [NUM_CH-1:0] oeFsm, okReg, pf, fEntry;
  logic [CHW-1:0]    entryCh;
  logic              bypass;

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    ddr5_pwrgd_ch #(
      .FILT_CYCLES   (FILT_CYCLES),
      .LINK_TO_CYCLES(LINK_TO_CYCLES),
      .FAULT_STICKY  (FAULT_STICKY)
    ) uCh (
      .iClk      (iClk),
      .iRst      (iRst),
      .psOk      (iPWRGD_PS_PWROK),
      .ddrio     (iPWRGD_DRAMPWRGD_DDRIO[i]),
      .pin       (iPWRGD_FAIL_CH[i]),
      .oe        (oeFsm[i]),
      .dramOk    (okReg[i]),
      .pfOut     (pf[i]),
      .memFlt    (oDIMM_MEM_FLT[i]),
      .cause     (oFLT_CAUSE[2*i +: 2]),
      .faultEntry(fEntry[i])
    );
  end

  // Bypass paths are gated by reset so reset always wins on the pins.
  assign bypass = iFM_INTR_PRSNT & iINTR_SKU & ~iRst;

  assign oPWRGD_FAIL_OE = oeFsm | {NUM_CH{~iADR_LOGIC}};

  assign oPWRGD_DRAMPWRGD_OK =
    bypass ? iPWRGD_DRAMPWRGD_DDRIO : okReg;

  assign oFPGA_DIMM_RST_N =
    bypass ? iMC_RST_N : (iMC_RST_N & okReg & pf);

  // Scan downward so the lowest simultaneous entry wins.
  always_comb begin
    entryCh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fEntry[i]) entryCh = CHW'(i);
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oFIRST_FLT_VALID <= LOW;
      oFIRST_FLT_CH    <= '0;
    end else if (!oFIRST_FLT_VALID && (|fEntry)) begin
      oFIRST_FLT_VALID <= HIGH;
      oFIRST_FLT_CH    <= entryCh;
    end else if (FAULT_STICKY == 0 && !iPWRGD_PS_PWROK) begin
      oFIRST_FLT_VALID <= LOW;
      oFIRST_FLT_CH    <= '0;
    end
  end

endmodule

// File: tb/tb_ddr5_pwrgd_multi_ch.sv
// Directed bench for ddr5_pwrgd_multi_ch: sticky and non-sticky instances
// share stimulus; expected values go through a scoreboard queue.
module tb_ddr5_pwrgd_multi_ch;

  localparam int N = 4;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic         iRst, prsnt, sku, ps, adr;
  logic [N-1:0] ddrio, mcRst, pinLow, pinA, pinB;

  logic [N-1:0]   oeA, okA, rstA, fltA;
  logic [2*N-1:0] causeA;
  logic           vA;
  logic [1:0]     chA;

  logic [N-1:0]   oeB, okB, rstB, fltB;
  logic [2*N-1:0] causeB;
  logic           vB;
  logic [1:0]     chB;

  // Pins are pulled up externally; the bench can also force one low.
  assign pinA = ~oeA & ~pinLow;
  assign pinB = ~oeB & ~pinLow;

  ddr5_pwrgd_multi_ch #(
    .NUM_CH(N), .FILT_CYCLES(4), .LINK_TO_CYCLES(100), .FAULT_STICKY(1)
  ) dutA (
    .iClk(iClk), .iRst(iRst),
    .iFM_INTR_PRSNT(prsnt), .iINTR_SKU(sku),
    .iPWRGD_PS_PWROK(ps), .iPWRGD_DRAMPWRGD_DDRIO(ddrio),
    .iMC_RST_N(mcRst), .iADR_LOGIC(adr), .iPWRGD_FAIL_CH(pinA),
    .oPWRGD_FAIL_OE(oeA), .oPWRGD_DRAMPWRGD_OK(okA),
    .oFPGA_DIMM_RST_N(rstA), .oDIMM_MEM_FLT(fltA),
    .oFLT_CAUSE(causeA), .oFIRST_FLT_VALID(vA), .oFIRST_FLT_CH(chA)
  );

  ddr5_pwrgd_multi_ch #(
    .NUM_CH(N), .FILT_CYCLES(4), .LINK_TO_CYCLES(100), .FAULT_STICKY(0)
  ) dutB (
    .iClk(iClk), .iRst(iRst),
    .iFM_INTR_PRSNT(prsnt), .iINTR_SKU(sku),
    .iPWRGD_PS_PWROK(ps), .iPWRGD_DRAMPWRGD_DDRIO(ddrio),
    .iMC_RST_N(mcRst), .iADR_LOGIC(adr), .iPWRGD_FAIL_CH(pinB),
    .oPWRGD_FAIL_OE(oeB), .oPWRGD_DRAMPWRGD_OK(okB),
    .oFPGA_DIMM_RST_N(rstB), .oDIMM_MEM_FLT(fltB),
    .oFLT_CAUSE(causeB), .oFIRST_FLT_VALID(vB), .oFIRST_FLT_CH(chB)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  nAssert = 0;
  int  nFail   = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    e = sbq.pop_front();
    nAssert++;
    assert (obs === e.exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    int n;
    int cnt;
    iRst = 1'b1; prsnt = 1'b0; sku = 1'b0; ps = 1'b0; adr = 1'b1;
    ddrio = '0; mcRst = 4'hF; pinLow = '0;
    cyc(2);

    push("rst_oe", 4'hF);  chk(32'(oeA));
    push("rst_ok", 4'h0);  chk(32'(okA));
    push("rst_dimm", 4'h0); chk(32'(rstA));
    push("rst_flt", 4'h0); chk(32'(fltA));
    push("rst_cause", 8'h00); chk(32'(causeA));
    push("rst_valid", 1'b0); chk(32'(vA));
    push("rst_ch", 2'd0);  chk(32'(chA));

    // Power up all channels into LINK.
    iRst = 1'b0; ps = 1'b1; ddrio = 4'hF;
    push("up_ok", 4'hF);
    n = 0;
    while (okA !== 4'hF && n < 40) begin cyc(1); n++; end
    chk(32'(okA));
    push("up_dimm", 4'hF); chk(32'(rstA));
    mcRst = 4'hA; #1;
    push("up_dimm_a", 4'hA); chk(32'(rstA));
    push("up_flt", 4'h0); chk(32'(fltA));
    push("up_oe", 4'h0); chk(32'(oeA));

    // ADR gate forces all pins low combinationally.
    cyc(1); adr = 1'b0; #1;
    push("adr_oe", 4'hF); chk(32'(oeA));
    cyc(1); adr = 1'b1;
    cyc(5);

    // A 3-cycle glitch is filtered out.
    pinLow = 4'b0100; cyc(3); pinLow = '0; cyc(10);
    push("glitch_flt", 4'h0); chk(32'(fltA));
    push("glitch_ok", 4'hF); chk(32'(okA));

    // A 6-cycle low faults channel 2.
    pinLow = 4'b0100; cyc(6); pinLow = '0;
    push("pg_flt", 4'b0100);
    n = 0;
    while (fltA === 4'h0 && n < 20) begin cyc(1); n++; end
    chk(32'(fltA));
    push("pg_cause2", 2'b10); chk(32'(causeA[5:4]));
    push("pg_valid", 1'b1); chk(32'(vA));
    push("pg_ch", 2'd2); chk(32'(chA));
    push("pg_oe", 4'b0100); chk(32'(oeA));

    // One cycle of PSU loss: only the non-sticky instance clears.
    ps = 1'b0; pinLow = 4'b0010; cyc(1);
    push("ns_flt", 4'h0); chk(32'(fltB));
    push("ns_cause", 8'h00); chk(32'(causeB));
    push("ns_valid", 1'b0); chk(32'(vB));
    push("ns_ok", 4'h0); chk(32'(okB));
    push("st_flt", 4'b0100); chk(32'(fltA));
    push("st_ch", 2'd2); chk(32'(chA));

    // Pin 1 held low: count cycles spent in DDRIO before timeout.
    cyc(10); ps = 1'b1;
    n = 0; cnt = 0;
    while (fltA[1] !== 1'b1 && n < 400) begin
      cyc(1); n++;
      if (oeA[1] === 1'b0) cnt++;
    end
    push("to_cycles", 100); chk(32'(cnt));
    push("to_cause1", 2'b11); chk(32'(causeA[3:2]));
    push("to_flt", 4'b0110); chk(32'(fltA));
    push("to_ch_keep", 2'd2); chk(32'(chA));
    push("to_b_flt", 4'b0010); chk(32'(fltB));
    push("to_b_ch", 2'd1); chk(32'(chB));

    // Simultaneous DDRIO drop on channels 0 and 3.
    pinLow = '0; ps = 1'b0; cyc(10); ps = 1'b1;
    push("sim_up_b", 4'hF);
    n = 0;
    while (okB !== 4'hF && n < 60) begin cyc(1); n++; end
    chk(32'(okB));
    ddrio = 4'b0110; cyc(1);
    push("sim_flt_a", 4'hF); chk(32'(fltA));
    push("sim_cause_a", 8'h6D); chk(32'(causeA));
    push("sim_ch_a", 2'd2); chk(32'(chA));
    push("sim_flt_b", 4'b1001); chk(32'(fltB));
    push("sim_cause_b", 8'h41); chk(32'(causeB));
    push("sim_valid_b", 1'b1); chk(32'(vB));
    push("sim_ch_b", 2'd0); chk(32'(chB));

    // Interposer bypass mirrors inputs; FSM faults remain.
    prsnt = 1'b1; sku = 1'b1; #1;
    push("byp_ok", 4'b0110); chk(32'(okA));
    ddrio = 4'b1011; #1;
    push("byp_ok2", 4'b1011); chk(32'(okA));
    mcRst = 4'h5; #1;
    push("byp_dimm", 4'h5); chk(32'(rstA));
    push("byp_flt", 4'hF); chk(32'(fltA));
    prsnt = 1'b0; #1;
    push("nobyp_ok", 4'h0); chk(32'(okA));
    push("nobyp_dimm", 4'h0); chk(32'(rstA));

    // Asynchronous reset while in LINK.
    cyc(1); iRst = 1'b1; cyc(1); iRst = 1'b0;
    ddrio = 4'hF; mcRst = 4'hF;
    push("rl_up", 4'hF);
    n = 0;
    while (okA !== 4'hF && n < 40) begin cyc(1); n++; end
    chk(32'(okA));
    cyc(3); #2 iRst = 1'b1; #1;
    push("rl_oe", 4'hF); chk(32'(oeA));
    push("rl_ok", 4'h0); chk(32'(okA));
    push("rl_dimm", 4'h0); chk(32'(rstA));
    push("rl_flt", 4'h0); chk(32'(fltA));
    push("rl_cause", 8'h00); chk(32'(causeA));
    push("rl_valid", 1'b0); chk(32'(vA));

    #10;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/ddr5_pwrgd_multi_ch.md
Name: ddr5_pwrgd_multi_ch

Overview:
Parametrised multi-channel DDR5 PWRGD_FAIL controller. It runs one power-good/fault state machine per memory channel. Each channel input is synchronised and debounced, there is a timeout on DIMM link-up, and the block records a per-channel fault cause plus the first channel to fault. It sits between the PSU/DDRIO power-good sources and the per-channel open-drain PWRGD_FAIL pins, and drives DRAMPWRGD_OK and DIMM reset for each channel.

Parameters:
NUM_CH, 8, number of memory channels (1..16)
FILT_CYCLES, 4, consecutive stable synchronised samples needed to accept a PWRGD_FAIL level change (>=1)
LINK_TO_CYCLES, 2000, maximum iClk cycles in ST_DDRIO waiting for PWRGD_FAIL high; 0 disables the timeout
FAULT_STICKY, 1, 1 = a fault clears only on iRst; 0 = a fault also clears when iPWRGD_PS_PWROK is low

Ports:
iClk  in  1  system clock
iRst  in  1  asynchronous, active-high reset
iFM_INTR_PRSNT  in  1  interposer present
iINTR_SKU  in  1  interposer SKU (1 = DDR4 bypass)
iPWRGD_PS_PWROK  in  1  PSU power good
iPWRGD_DRAMPWRGD_DDRIO  in  NUM_CH  per-channel iMC VR power good
iMC_RST_N  in  NUM_CH  per-channel memory-controller reset
iADR_LOGIC  in  1  ADR gate; 0 forces all PWRGD_FAIL pins low
iPWRGD_FAIL_CH  in  NUM_CH  pad input of the PWRGD_FAIL pins (asynchronous)
oPWRGD_FAIL_OE  out  NUM_CH  1 = drive pin low; 0 = float (open drain)
oPWRGD_DRAMPWRGD_OK  out  NUM_CH  per-channel DRAM power OK
oFPGA_DIMM_RST_N  out  NUM_CH  per-channel DIMM reset
oDIMM_MEM_FLT  out  NUM_CH  per-channel fault flag
oFLT_CAUSE  out  2*NUM_CH  cause per channel: 00 none, 01 DDRIO drop, 10 PWRGD_FAIL low in LINK, 11 link timeout
oFIRST_FLT_VALID  out  1  a first fault has been captured
oFIRST_FLT_CH  out  $clog2(NUM_CH) (min 1)  index of the first faulting channel

Behaviour:
- Reset values: all OE=1 (pins driven low), DRAMPWRGD_OK=0, DIMM_RST_N=0, MEM_FLT=0, FLT_CAUSE=0, FIRST_FLT_VALID=0, FIRST_FLT_CH=0. All FSMs start in ST_IDLE; filters preset to 0.
- Input filtering, per channel:
  - 2-flop synchroniser, then a filtered level pf that changes only after FILT_CYCLES consecutive equal synchronised samples.
  - Pin-to-pf latency is 2+FILT_CYCLES cycles.
- Per-channel FSM:
  - ST_IDLE: OE=1. Go to ST_PSU when PS_PWROK=1.
  - ST_PSU: OE=1. Go to ST_IDLE if PS_PWROK=0. Go to ST_DDRIO if DDRIO[i]=1.
  - ST_DDRIO: OE=0 and timeout counter runs. Go to ST_IDLE if PS_PWROK=0. Go to ST_LINK if DDRIO[i]=1 and pf=1. Go to ST_PSU if DDRIO[i]=0. Go to ST_FAULT with cause 11 when the counter reaches LINK_TO_CYCLES. The counter is cleared on every entry to ST_DDRIO.
  - ST_LINK: DRAMPWRGD_OK=1 (registered, asserts the cycle after entry). Go to ST_IDLE if PS_PWROK=0. Go to ST_FAULT if DDRIO[i]=0 (cause 01) or pf=0 (cause 10). If both are low, cause 01 wins.
  - ST_FAULT: OE=1, DRAMPWRGD_OK=0, MEM_FLT=1, cause held. When FAULT_STICKY=0 and PS_PWROK=0, go to ST_IDLE and clear MEM_FLT and cause.
- PS_PWROK=0 in any non-fault state returns to ST_IDLE the next cycle and deasserts DRAMPWRGD_OK.
- Pin drive: effective OE[i] = OE_fsm[i] OR NOT iADR_LOGIC (combinational). ADR does not change FSM state directly. A resulting pf=0 in ST_LINK is a cause-10 fault.
- DIMM reset: oFPGA_DIMM_RST_N[i] = iMC_RST_N[i] when DRAMPWRGD_OK_reg[i]=1 and pf[i]=1, else 0.
- Interposer bypass: when iFM_INTR_PRSNT and iINTR_SKU are both 1:
  - oFPGA_DIMM_RST_N = iMC_RST_N
  - oPWRGD_DRAMPWRGD_OK = iPWRGD_DRAMPWRGD_DDRIO
  - FSMs keep running and MEM_FLT and cause still update.
- First-fault capture:
  - On the first cycle any channel enters ST_FAULT while FIRST_FLT_VALID=0, set VALID and record the channel index.
  - Simultaneous entries: the lowest index wins.
  - Once set, later faults do not change it. It clears only on iRst, or on a non-sticky clear when no channel remains in ST_FAULT.
- Reset mid-operation: the asynchronous iRst immediately forces all outputs to their reset values, whatever the state.

Decomposition:
- Package ddr5_pwrgd_pkg:
  - state encodings ST_IDLE..ST_FAULT (3 bits)
  - cause codes CAUSE_NONE/DDRIO/PGFAIL/TIMEOUT
  - LOW/HIGH constants
- Sub-module ddr5_pwrgd_ch:
  - one channel: synchroniser, debounce, FSM, timeout counter, cause
  - instantiated NUM_CH times by a generate loop
- The top level holds the ADR/interposer muxing and the first-fault priority encoder.

Test Plan:
- NUM_CH=4, FILT=4, TO=100; PS_PWROK=1, DDRIO=4'hF, all pins pulled high -> DRAMPWRGD_OK=4'hF by cycle 2+4+~3; DIMM_RST_N follows iMC_RST_N; MEM_FLT=0.
- In LINK, a 3-cycle low glitch on pin 2 -> no fault. A 6-cycle low on pin 2 -> MEM_FLT=4'b0100, cause[2]=10, FIRST_FLT_CH=2, OE[2]=1.
- Pin 1 held low in DDRIO -> after exactly 100 cycles in ST_DDRIO, cause[1]=11 and MEM_FLT[1]=1.
- DDRIO[0] and DDRIO[3] drop in the same cycle from LINK -> both faults have cause 01; FIRST_FLT_CH=0.
- FAULT_STICKY=0: after a fault, PS_PWROK low for 1 cycle -> MEM_FLT and cause cleared and FIRST_FLT_VALID=0. FAULT_STICKY=1: the fault persists until iRst.
- Interposer with SKU=1 -> DRAMPWRGD_OK mirrors DDRIO and DIMM_RST_N mirrors iMC_RST_N. iADR_LOGIC=0 -> OE=4'hF; iRst mid-LINK -> all outputs return to reset values asynchronously.
